// File: rtl/csa_pkg.sv
// Shared definitions for the CSA transmit path.
// CSA_W        : width of one CSA word (32 data bits plus the SOP flag)
// CSA_SOP_BIT  : position of the start-of-frame flag inside a word
// CSA_*_WORDS  : frame geometry (the SOP word plus 8 header words, then 47 TS payload words)
// csa_sched_state_t : state encoding of the csa_tx_sched arbiter FSM
package csa_pkg;

  localparam int CSA_W           = 33;
  localparam int CSA_SOP_BIT     = 32;
  localparam int CSA_HDR_WORDS   = 9;
  localparam int CSA_TS_WORDS    = 47;
  localparam int CSA_FRAME_WORDS = CSA_HDR_WORDS + CSA_TS_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } csa_sched_state_t;

endpackage

// File: rtl/csa_rr_pick.sv
// Combinational round-robin picker.
// req     : request vector, one bit per requester
// last    : index of the requester served most recently
// gnt_oh  : one-hot grant (all zero when no request)
// gnt_idx : index of the granted requester (0 when no request)
// gnt_any : at least one request present
// The search starts at last+1 and wraps modulo N_REQ, so 'last' itself
// is considered only after every other requester.
module csa_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         gnt_oh,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % N_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csa_tx_sched.sv
// Frame-atomic round-robin scheduler feeding one csa_tx scrambler.
// clk_main     : system clock
// rst          : synchronous active-high reset
// in_valid     : per-requester word valid
// in_data      : per-requester 33-bit word, requester r at [33r+32:33r], bit 32 = SOP
// in_last      : per-requester final-word flag
// in_ready     : per-requester accept (combinational)
// csa_data     : registered word towards csa_tx.ts_in_csa
// csa_en       : registered enable towards csa_tx.en_in_csa
// grant_id     : requester owning the current or last frame
// err_underrun : pulse, frame aborted (valid gap or SOP inside a frame)
// err_length   : pulse, frame cut at FRAME_WORDS
// err_sop      : pulse, non-SOP word discarded while idle
module csa_tx_sched
  import csa_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int FRAME_WORDS = 56,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk_main,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [N_REQ*CSA_W-1:0]   in_data,
  input  logic [N_REQ-1:0]         in_last,
  output logic [N_REQ-1:0]         in_ready,
  output logic [CSA_W-1:0]         csa_data,
  output logic                     csa_en,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_underrun,
  output logic                     err_length,
  output logic                     err_sop
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);

  csa_sched_state_t state;
  logic [IDX_W-1:0] last_grant;
  logic [N_REQ-1:0] grant_oh;
  logic [CNT_W-1:0] word_cnt;
  logic [3:0]       gap_cnt;

  logic [N_REQ-1:0] sop_vec_p0;
  logic [N_REQ-1:0] cand_p0;
  logic [N_REQ-1:0] discard_p0;
  logic [CSA_W-1:0] sel_word_p0;
  logic             sel_vld_p0;
  logic             sel_last_p0;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  // ---- stage p0: request decode and granted-requester mux ----
  always_comb begin
    sop_vec_p0  = '0;
    sel_word_p0 = '0;
    sel_vld_p0  = 1'b0;
    sel_last_p0 = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      sop_vec_p0[r] = in_data[r*CSA_W + CSA_SOP_BIT];
      if (grant_oh[r]) begin
        sel_word_p0 = in_data[r*CSA_W +: CSA_W];
        sel_vld_p0  = in_valid[r];
        sel_last_p0 = in_last[r];
      end
    end
    cand_p0    = in_valid & sop_vec_p0;
    discard_p0 = in_valid & ~sop_vec_p0;
  end

  csa_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (cand_p0),
    .last    (last_grant),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Idle discards stray non-SOP words so a stalled tail cannot block arbitration.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: in_ready = discard_p0;
        ST_XFER: in_ready = grant_oh;
        default: in_ready = '0;
      endcase
    end
  end

  // ---- stage p1: FSM and registered output word ----
  always_ff @(posedge clk_main) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= IDX_W'(N_REQ - 1);
      grant_id     <= '0;
      grant_oh     <= '0;
      word_cnt     <= '0;
      gap_cnt      <= '0;
      csa_en       <= 1'b0;
      csa_data     <= '0;
      err_underrun <= 1'b0;
      err_length   <= 1'b0;
      err_sop      <= 1'b0;
    end else begin
      csa_en       <= 1'b0;
      err_underrun <= 1'b0;
      err_length   <= 1'b0;
      err_sop      <= 1'b0;
      case (state)
        ST_IDLE: begin
          err_sop  <= |discard_p0;
          word_cnt <= '0;
          if (pick_any) begin
            grant_id <= pick_idx;
            grant_oh <= pick_oh;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (sel_vld_p0) begin
            csa_data <= sel_word_p0;
            csa_en   <= 1'b1;
            word_cnt <= word_cnt + CNT_W'(1);
            // A second SOP means the requester restarted; the word still goes out.
            if (sel_word_p0[CSA_SOP_BIT] && word_cnt != '0) begin
              err_underrun <= 1'b1;
              state        <= ST_GAP;
            end else if (sel_last_p0) begin
              state <= ST_GAP;
            end else if (word_cnt == CNT_W'(FRAME_WORDS - 1)) begin
              err_length <= 1'b1;
              state      <= ST_GAP;
            end
          end else if (word_cnt != '0) begin
            // Before the SOP is taken a missing valid is just a wait.
            err_underrun <= 1'b1;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          last_grant <= grant_id;
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_tx_sched.sv
module tb_csa_tx_sched;

  localparam int N   = 4;
  localparam int W   = 33;
  localparam int GAP = 2;

  logic           clk_main = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   csa_data;
  logic           csa_en;
  logic [1:0]     grant_id;
  logic           err_underrun;
  logic           err_length;
  logic           err_sop;

  csa_tx_sched #(
    .N_REQ       (N),
    .FRAME_WORDS (56),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk_main     (clk_main),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .csa_data     (csa_data),
    .csa_en       (csa_en),
    .grant_id     (grant_id),
    .err_underrun (err_underrun),
    .err_length   (err_length),
    .err_sop      (err_sop)
  );

  always #5 clk_main = ~clk_main;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_und    = 0;
  int n_len    = 0;
  int n_sop    = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   gnt;
    int           cyc;
  } obs_t;

  typedef struct {
    int r;
    int f;
    int len;
  } fr_t;

  typedef struct {
    logic [3:0]   vld;
    int           req;
    logic [W-1:0] word;
    logic         last;
    logic [3:0]   e_rdy;
    logic         e_en;
    logic [W-1:0] e_data;
    logic [1:0]   e_gnt;
    logic         e_sop;
    logic         e_und;
  } vec_t;

  obs_t out_q[$];
  fr_t  exp_q[$];
  vec_t tv[19];

  always @(posedge clk_main) cyc <= cyc + 1;

  always @(negedge clk_main) begin
    if (csa_en) out_q.push_back('{csa_data, grant_id, cyc});
    if (err_underrun) n_und <= n_und + 1;
    if (err_length) n_len <= n_len + 1;
    if (err_sop) n_sop <= n_sop + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int r, input int f, input int i);
    logic [31:0] hdr;
    int k;
    if (r == 0 && f == 0) begin
      if (i == 0) return 33'h1_0000_0001;
      if (i < 9) begin
        case (i)
          1: hdr = 32'h0000_0000;
          2: hdr = 32'h0123_4567;
          3: hdr = 32'h89AB_CDEF;
          4: hdr = 32'h0F1E_2D3C;
          5: hdr = 32'h4B5A_6978;
          6: hdr = 32'h0000_0010;
          7: hdr = 32'h0000_0020;
          default: hdr = 32'h0000_00BC;
        endcase
        return {1'b0, hdr};
      end
      k = i - 9;
      return {1'b0, 8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
    end
    return {(i == 0), 8'(r), 8'(f), 16'(i)};
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    repeat (2) @(posedge clk_main);
    #1;
    rst = 1'b0;
  endtask

  // Drives all requesters at once, honouring in_ready. drop_r/drop_at withdraws
  // valid for one cycle at that word of frame 0, abandoning the frame.
  task automatic run_traffic(input int f0, input int f1, input int f2, input int f3,
                             input int nw, input bit use_last,
                             input int drop_r, input int drop_at, output int t0);
    int nfr[4];
    int fi[4];
    int wi[4];
    bit pres[4];
    bit drop_now[4];
    bit dropped;
    bit done;
    logic [N-1:0] rdy;
    int budget;
    nfr = '{f0, f1, f2, f3};
    fi  = '{default: 0};
    wi  = '{default: 0};
    dropped = 1'b0;
    budget  = 0;
    t0 = cyc;
    done = 1'b0;
    while (!done && budget < 3000) begin
      in_valid = '0;
      in_data  = '0;
      in_last  = '0;
      for (int r = 0; r < N; r++) begin
        pres[r]     = 1'b0;
        drop_now[r] = 1'b0;
        if (fi[r] < nfr[r]) begin
          if (r == drop_r && fi[r] == 0 && wi[r] == drop_at && !dropped) begin
            drop_now[r] = 1'b1;
          end else begin
            in_valid[r]         = 1'b1;
            in_data[r*W +: W]   = word_of(r, fi[r], wi[r]);
            in_last[r]          = use_last && (wi[r] == nw - 1);
            pres[r]             = 1'b1;
          end
        end
      end
      #2;
      rdy = in_ready;
      @(posedge clk_main);
      #1;
      budget++;
      for (int r = 0; r < N; r++) begin
        if (drop_now[r]) begin
          dropped = 1'b1;
          fi[r]++;
          wi[r] = 0;
        end else if (pres[r] && rdy[r]) begin
          wi[r]++;
          if (wi[r] == nw) begin
            wi[r] = 0;
            fi[r]++;
          end
        end
      end
      done = 1'b1;
      for (int r = 0; r < N; r++) if (fi[r] < nfr[r]) done = 1'b0;
    end
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    chk("traffic_done", 64'(done), 64'd1);
    repeat (12) @(posedge clk_main);
    #1;
  endtask

  task automatic check_frames(input string tag, input int start);
    int fs[$];
    int fl[$];
    int n;
    int len;
    int idle;
    for (int i = start; i < out_q.size(); i++) begin
      if (i == start || out_q[i].cyc != out_q[i-1].cyc + 1) begin
        fs.push_back(i);
        fl.push_back(1);
      end else begin
        fl[fl.size()-1] = fl[fl.size()-1] + 1;
      end
    end
    chk({tag, "_nframes"}, 64'(fs.size()), 64'(exp_q.size()));
    n = (fs.size() < exp_q.size()) ? fs.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_len%0d", tag, k), 64'(fl[k]), 64'(exp_q[k].len));
      chk($sformatf("%s_gnt%0d", tag, k), 64'(out_q[fs[k]].gnt), 64'(exp_q[k].r));
      len = (fl[k] < exp_q[k].len) ? fl[k] : exp_q[k].len;
      for (int i = 0; i < len; i++)
        chk($sformatf("%s_f%0d_w%0d", tag, k, i), 64'(out_q[fs[k]+i].data),
            64'(word_of(exp_q[k].r, exp_q[k].f, i)));
      if (k > 0) begin
        idle = out_q[fs[k]].cyc - out_q[fs[k-1] + fl[k-1] - 1].cyc - 1;
        chk($sformatf("%s_gap_ok%0d", tag, k), 64'(idle >= GAP + 1), 64'd1);
      end
    end
  endtask

  initial begin
    int start;
    int t0;
    int base_und;
    int base_len;
    int base_sop;
    int acc;
    int tmo;
    bit ok;

    //        vld      req word            last rdy      en  data            gnt  sop und
    tv[0]  = '{4'b1000, 3, 33'h0_DEAD_BEEF, 0, 4'b1000, 0, 33'h0,           2'd0, 0, 0};
    tv[1]  = '{4'b0000, 0, 33'h0,           0, 4'b0000, 0, 33'h0,           2'd0, 1, 0};
    tv[2]  = '{4'b0010, 1, 33'h1_0000_0011, 0, 4'b0000, 0, 33'h0,           2'd0, 0, 0};
    tv[3]  = '{4'b0010, 1, 33'h1_0000_0011, 0, 4'b0010, 0, 33'h0,           2'd1, 0, 0};
    tv[4]  = '{4'b0010, 1, 33'h0_0000_0012, 0, 4'b0010, 1, 33'h1_0000_0011, 2'd1, 0, 0};
    tv[5]  = '{4'b0010, 1, 33'h0_0000_0013, 1, 4'b0010, 1, 33'h0_0000_0012, 2'd1, 0, 0};
    tv[6]  = '{4'b0000, 0, 33'h0,           0, 4'b0000, 1, 33'h0_0000_0013, 2'd1, 0, 0};
    tv[7]  = '{4'b0001, 0, 33'h1_0000_0021, 0, 4'b0000, 0, 33'h0_0000_0013, 2'd1, 0, 0};
    tv[8]  = '{4'b0001, 0, 33'h1_0000_0021, 0, 4'b0000, 0, 33'h0_0000_0013, 2'd1, 0, 0};
    tv[9]  = '{4'b0001, 0, 33'h1_0000_0021, 0, 4'b0001, 0, 33'h0_0000_0013, 2'd0, 0, 0};
    tv[10] = '{4'b0001, 0, 33'h0_0000_0022, 1, 4'b0001, 1, 33'h1_0000_0021, 2'd0, 0, 0};
    tv[11] = '{4'b0000, 0, 33'h0,           0, 4'b0000, 1, 33'h0_0000_0022, 2'd0, 0, 0};
    tv[12] = '{4'b0100, 2, 33'h1_0000_0031, 0, 4'b0000, 0, 33'h0_0000_0022, 2'd0, 0, 0};
    tv[13] = '{4'b0100, 2, 33'h1_0000_0031, 0, 4'b0000, 0, 33'h0_0000_0022, 2'd0, 0, 0};
    tv[14] = '{4'b0100, 2, 33'h1_0000_0031, 0, 4'b0100, 0, 33'h0_0000_0022, 2'd2, 0, 0};
    tv[15] = '{4'b0100, 2, 33'h0_0000_0032, 0, 4'b0100, 1, 33'h1_0000_0031, 2'd2, 0, 0};
    tv[16] = '{4'b0000, 0, 33'h0,           0, 4'b0100, 1, 33'h0_0000_0032, 2'd2, 0, 0};
    tv[17] = '{4'b0000, 0, 33'h0,           0, 4'b0000, 0, 33'h0_0000_0032, 2'd2, 0, 1};
    tv[18] = '{4'b0000, 0, 33'h0,           0, 4'b0000, 0, 33'h0_0000_0032, 2'd2, 0, 0};

    do_reset();
    chk("reset_err_length", 64'(err_length), 64'd0);

    // Cycle-exact vectors: stray non-SOP discard, short frame, rotation, underrun.
    for (int k = 0; k < 19; k++) begin
      in_data = '0;
      if (tv[k].vld != 4'b0000) in_data[tv[k].req*W +: W] = tv[k].word;
      in_valid = tv[k].vld;
      in_last  = tv[k].last ? tv[k].vld : 4'b0000;
      #2;
      chk($sformatf("vec%0d_ready", k), 64'(in_ready), 64'(tv[k].e_rdy));
      chk($sformatf("vec%0d_en", k), 64'(csa_en), 64'(tv[k].e_en));
      chk($sformatf("vec%0d_data", k), 64'(csa_data), 64'(tv[k].e_data));
      chk($sformatf("vec%0d_grant", k), 64'(grant_id), 64'(tv[k].e_gnt));
      chk($sformatf("vec%0d_err_sop", k), 64'(err_sop), 64'(tv[k].e_sop));
      chk($sformatf("vec%0d_err_underrun", k), 64'(err_underrun), 64'(tv[k].e_und));
      chk($sformatf("vec%0d_err_length", k), 64'(err_length), 64'd0);
      @(posedge clk_main);
      #1;
    end
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;

    // Full 56-word frame on requester 0.
    do_reset();
    start = out_q.size();
    exp_q.delete();
    exp_q.push_back('{0, 0, 56});
    run_traffic(1, 0, 0, 0, 56, 1'b1, -1, 0, t0);
    check_frames("single", start);
    if (out_q.size() > start)
      chk("single_latency", 64'(out_q[start].cyc - t0), 64'd2);
    else
      chk("single_latency_present", 64'(out_q.size()), 64'(start + 1));

    // All four requesters contend, four frames each.
    do_reset();
    start = out_q.size();
    exp_q.delete();
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 4; r++) exp_q.push_back('{r, f, 5});
    run_traffic(4, 4, 4, 4, 5, 1'b1, -1, 0, t0);
    check_frames("rr", start);

    // Requester 2 drops valid at word 10, then sends a clean frame.
    do_reset();
    start    = out_q.size();
    base_und = n_und;
    exp_q.delete();
    exp_q.push_back('{2, 0, 10});
    exp_q.push_back('{2, 1, 20});
    run_traffic(0, 0, 2, 0, 20, 1'b1, 2, 10, t0);
    check_frames("underrun", start);
    chk("underrun_pulses", 64'(n_und - base_und), 64'd1);

    // Requester 1 sends 60 words without a last flag.
    do_reset();
    start    = out_q.size();
    base_len = n_len;
    base_sop = n_sop;
    base_und = n_und;
    exp_q.delete();
    exp_q.push_back('{1, 0, 56});
    run_traffic(0, 1, 0, 0, 60, 1'b0, -1, 0, t0);
    check_frames("length", start);
    chk("length_pulses", 64'(n_len - base_len), 64'd1);
    chk("length_sop_pulses", 64'(n_sop - base_sop), 64'd4);
    chk("length_no_underrun", 64'(n_und - base_und), 64'd0);

    // Reset in the middle of a frame.
    do_reset();
    acc = 0;
    tmo = 0;
    while (acc < 20 && tmo < 100) begin
      in_data  = '0;
      in_data[0 +: W] = word_of(0, 9, acc);
      in_valid = 4'b0001;
      in_last  = '0;
      #2;
      ok = in_ready[0];
      @(posedge clk_main);
      #1;
      tmo++;
      if (ok) acc++;
    end
    chk("rst_words_sent", 64'(acc), 64'd20);
    chk("rst_pre_en", 64'(csa_en), 64'd1);
    base_und = n_und;
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    #2;
    chk("rst_ready_same_cycle", 64'(in_ready), 64'd0);
    @(posedge clk_main);
    #1;
    chk("rst_en", 64'(csa_en), 64'd0);
    chk("rst_data", 64'(csa_data), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    rst = 1'b0;
    #2;
    chk("rst_ready_after", 64'(in_ready), 64'd0);
    @(posedge clk_main);
    #1;
    chk("rst_no_underrun", 64'(n_und - base_und), 64'd0);
    // Requesters 0 and 2 both ask; only a restored last_grant favours 0.
    in_data = '0;
    in_data[0 +: W]   = word_of(0, 10, 0);
    in_data[2*W +: W] = word_of(2, 10, 0);
    in_valid = 4'b0101;
    @(posedge clk_main);
    #2;
    chk("rst_first_grant", 64'(grant_id), 64'd0);
    chk("rst_first_ready", 64'(in_ready), 64'b0001);
    chk("rst_en_quiet", 64'(csa_en), 64'd0);
    #1;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
